// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uartState_e : 2-bit FSM state encoding used by both directions
//   DATA_BITS   : payload width of one frame
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        START_BIT = 2'b01,
        DATA      = 2'b10,
        STOP_BIT  = 2'b11
    } uartState_e;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_filter.sv
// uart_rx_filter: brings the asynchronous rx pin into the clk domain and
// produces the bit decision used by the receiver FSM.
//   clk, rst : clock, asynchronous active-high reset
//   rx       : raw serial pin (idle high)
//   rxS      : synchronised line level, used for edge/idle detection
//   rxBit    : bit decision used when sampling start/data/stop bits
// Build option UART_RX_MAJORITY_VOTE_EN: rxBit is the majority of the
// last three rxS samples (single-cycle glitches rejected, one extra
// cycle of latency on rxS). Without it rxBit is rxS.
module uart_rx_filter (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxS,
    output logic rxBit
);

    // Reset to the idle level so leaving reset never looks like a start bit.
    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist[0] is the current rxS, hist[2:1] the two previous samples.
    logic [2:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 3'b111;
        end else begin
            hist <= {hist[1:0], sync[1]};
        end
    end

    assign rxS   = hist[0];
    assign rxBit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign rxS   = sync[1];
    assign rxBit = sync[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver sharing the transmitter's baud setting.
//   clk, rst      : clock, asynchronous active-high reset
//   cyclesPerBit  : clock cycles per bit (>= 4, static while busy)
//   rx            : serial line, asynchronous, idle high
//   dataOut       : last correctly received byte
//   dataAvailable : one-cycle strobe, dataOut just updated
//   framingError  : one-cycle strobe, stop bit sampled low
//   busy          : high whenever the FSM is not IDLE
// Build option UART_RX_MAJORITY_VOTE_EN is handled inside uart_rx_filter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, counters held at 0, waiting for rxS low
// START_BIT | wait half a bit, confirm start bit is still low
// DATA      | sample 8 data bits LSB first, one per bit period
// STOP_BIT  | sample stop bit; if low, report and wait for line release
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_SCALE_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        dataOut,
    output logic                        dataAvailable,
    output logic                        framingError,
    output logic                        busy
);

    localparam logic [CLOCK_SCALE_BITS-1:0] ONE = 1;

    logic                        rxS;
    logic                        rxBit;
    uartState_e                  state;
    logic [CLOCK_SCALE_BITS-1:0] count;
    logic [2:0]                  bitCounter;
    logic [DATA_BITS-1:0]        shift;
    logic                        inBreak;
    logic [CLOCK_SCALE_BITS-1:0] halfBit;
    logic [CLOCK_SCALE_BITS-1:0] lastCount;

    uart_rx_filter filter (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .rxS   (rxS),
        .rxBit (rxBit)
    );

    assign halfBit   = cyclesPerBit >> 1;
    // The counter is cleared on the sampling cycle, so a full bit period
    // ends when it reaches cyclesPerBit - 1.
    assign lastCount = cyclesPerBit - ONE;

    // Compares use >= so that a cyclesPerBit change mid-frame can only
    // shorten a bit period, never strand the FSM out of IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            bitCounter    <= '0;
            shift         <= '0;
            inBreak       <= 1'b0;
            dataOut       <= '0;
            dataAvailable <= 1'b0;
            framingError  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            dataAvailable <= 1'b0;
            framingError  <= 1'b0;
            case (state)
                IDLE: begin
                    count      <= '0;
                    bitCounter <= '0;
                    inBreak    <= 1'b0;
                    if (!rxS) begin
                        state <= START_BIT;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                START_BIT: begin
                    if (count >= halfBit) begin
                        count <= '0;
                        if (rxBit) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        count <= count + ONE;
                    end
                end
                DATA: begin
                    if (count >= lastCount) begin
                        count             <= '0;
                        shift[bitCounter] <= rxBit;
                        bitCounter        <= bitCounter + 3'd1;
                        if (bitCounter == 3'd7) begin
                            state <= STOP_BIT;
                        end
                    end else begin
                        count <= count + ONE;
                    end
                end
                STOP_BIT: begin
                    if (inBreak) begin
                        // Framing error already reported; wait for line release.
                        if (rxS) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            inBreak <= 1'b0;
                        end
                    end else if (count >= lastCount) begin
                        count <= '0;
                        if (rxBit) begin
                            dataOut       <= shift;
                            dataAvailable <= 1'b1;
                            state         <= IDLE;
                            busy          <= 1'b0;
                        end else begin
                            framingError <= 1'b1;
                            inBreak      <= 1'b1;
                        end
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART peripheral: recovers 8N1 frames from the asynchronous `rx` pin and presents each byte with a one-cycle strobe to the peripheral's register/FIFO logic. It is the receive-side counterpart of the peripheral's transmitter and shares its `cyclesPerBit` baud setting, so one register programs both directions. Line errors are reported as a one-cycle `framingError` strobe.

## Interface
Parameters:
- `CLOCK_SCALE_BITS`, default 16: width of the baud divider.

Ports:
- `clk`  input  1  single clock for the block.
- `rst`  input  1  reset, asynchronous and active-high.
- `cyclesPerBit`  input  CLOCK_SCALE_BITS  clock cycles per bit, computed as ((CLK_FREQ + BAUD) / BAUD) - 1. Must be at least 4.
- `rx`  input  1  serial line, asynchronous to `clk`, idle high.
- `dataOut`  output  8  last correctly received byte.
- `dataAvailable`  output  1  one-cycle strobe: `dataOut` has just been updated.
- `framingError`  output  1  one-cycle strobe: the stop bit was sampled low.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- `rx` always passes through a 2-flop synchroniser. The synchronised signal is `rxS`, and the bit decision `rxBit` is derived from it (see Configuration).
- `H = cyclesPerBit >> 1` (floor). All counter compares use CLOCK_SCALE_BITS-wide arithmetic, and `cyclesPerBit` is never widened.
- States are IDLE, START_BIT, DATA, STOP_BIT.
- **IDLE:** the counter and `bitCounter` are held at 0. When `rxS == 0`, go to START_BIT.
- **START_BIT:** count up to H, then check `rxBit`.
  - `rxBit == 1`: false start (glitch). Return to IDLE with no strobe.
  - `rxBit == 0`: clear the counter and go to DATA.
- **DATA:** count `cyclesPerBit` cycles, then sample `rxBit` into `shift[bitCounter]` (LSB first) and clear the counter. After bit 7, go to STOP_BIT.
- **STOP_BIT:** count `cyclesPerBit` cycles, then sample `rxBit`.
  - `rxBit == 1`: load `dataOut <= shift`, pulse `dataAvailable`, go to IDLE.
  - `rxBit == 0`: pulse `framingError` and leave `dataOut` unchanged. Stay in STOP_BIT, with no further strobes, until `rxS == 1` (break condition), then go to IDLE.
- The consumer must take `dataOut` within one frame time. There is no backpressure and no overrun flag; a new byte overwrites `dataOut`.
- `cyclesPerBit` must not change while `busy` is high. A change mid-frame has undefined frame results, but the FSM must still return to IDLE.
- An illegal state encoding goes to IDLE.

## Timing
- Reset values:
  - `dataOut` = 0x00, `dataAvailable` = 0, `framingError` = 0, `busy` = 0.
  - State = IDLE, all counters = 0.
  - Synchroniser flops = 1, so no false start is detected coming out of reset.
- Let t0 be the first cycle IDLE sees `rxS == 0`. This is 2 cycles after the pin edge, plus 1 cycle when majority voting is enabled.
- Start check at t0 + 1 + H.
- Data bit k (0..7) sampled at t0 + 1 + H + (k+1)·cyclesPerBit.
- Stop bit sampled at t0 + 1 + H + 9·cyclesPerBit. `dataAvailable` or `framingError` is high for exactly the following cycle.
- `busy` rises the cycle after t0 and falls in the same cycle the strobe rises.
- The next frame's falling edge can be accepted from the first IDLE cycle, so back-to-back frames with a single stop bit are received.
- Asserting `rst` mid-frame clears everything immediately (asynchronously). The partial byte is discarded and no strobe is produced.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN`
  - Defined: a 3-sample history of `rxS` is kept, and `rxBit` is the majority of the last 3 samples. Single-cycle glitches are rejected. Adds 1 cycle of latency to t0, as noted in Timing.
  - Undefined: `rxBit = rxS`, with no extra flops and no extra latency.

## Structure
- The shared package `uart_pkg` holds:
  - the 2-bit state encodings (IDLE=00, START_BIT=01, DATA=10, STOP_BIT=11), shared with the transmitter;
  - the 8-bit data-width constant.
- One sub-module, `uart_rx_filter`: the 2-flop synchroniser plus the optional majority vote. It outputs `rxS` and `rxBit`, and `uart_rx` instantiates it once.

## Test plan
- `cyclesPerBit` = 16; send 0xA5 as an 8N1 frame → `dataOut` = 0xA5 with one `dataAvailable` pulse at the computed cycle; `framingError` stays 0.
- Drive `rx` low for 4 cycles, then high → `busy` pulses briefly, no strobe, back in IDLE. A following 0x3C frame is received correctly.
- Frame 0x55 with the stop bit low, line held low for 40 cycles → one `framingError` pulse, `dataOut` keeps its prior value, `busy` stays high until `rx` returns high.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap → three `dataAvailable` pulses, with values in order.
- Assert `rst` after bit 3 of a frame → all outputs return to reset values; the next full 0x12 frame is received correctly.
- With `UART_RX_MAJORITY_VOTE_EN` defined, inject a 1-cycle inverted glitch at the centre of bit 2 of 0xF0 → `dataOut` = 0xF0. Without the macro, the same stimulus yields 0xF4.
